viterbi_conv_encoder_p: RTL and testbench
=========================================

# viterbi_conv_encoder_p

Parametrised, punctured convolutional encoder for the Viterbi transmit path: generalises the fixed rate-1/2 encoder of the tx/rx chain to configurable constraint length and generator polynomials, with run-time rate selection (1/2, 2/3, 3/4) and framed operation with automatic zero-tail termination. It feeds the channel/error-injection stage. Each coded bit carries a per-bit valid flag so the decoder can treat punctured positions as erasures.

## Interface
- K, 3: constraint length, legal 3..9; shift register holds K-1 bits
- G0, 3'b111: K-bit generator for c0; MSB taps the current input bit
- G1, 3'b101: K-bit generator for c1; same tap ordering as G0
- FRAME_LEN, 256: data bits per frame, legal 2..65535
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- encoder_i  input  1  data bit
- enable_encoder_i  input  1  encoder_i valid; bit accepted when enable_encoder_i && ready_o
- rate_sel_i  input  2  0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = treated as 1/2; latched at frame start
- ready_o  output  1  low while rst is high and during TAIL, high otherwise
- sym_o  output  2  coded pair, sym_o[0] = c0, sym_o[1] = c1; punctured bits driven 0
- sym_valid_o  output  2  per-bit keep mask; 0 = punctured (erasure)
- sym_strobe_o  output  1  sym_o/sym_valid_o hold a new symbol this cycle
- frame_start_o  output  1  pulses with the first symbol of a frame
- frame_end_o  output  1  pulses with the last tail symbol of a frame
- frame_ct_o  output  16  completed-frame count, wraps at 65535 -> 0

## Operation
- FSM states: IDLE, DATA, TAIL.
- IDLE: shift register sr is all zero. An accepted bit encodes, latches rate_sel_i, clears the puncture phase, loads bit_ct = 1, raises frame_start_o with that symbol, and moves to DATA. If FRAME_LEN is reached on this bit, go straight to TAIL.
- DATA: each accepted bit encodes and increments bit_ct. With enable low there is no shift, no strobe and no phase advance. On the FRAME_LEN-th accepted bit, go to TAIL.
- TAIL: shift in K-1 zero bits on consecutive cycles, independent of enable_encoder_i. Inputs are ignored. On the last tail bit, pulse frame_end_o, increment frame_ct_o and go to IDLE.
- Encoding: v = {in, sr}, with in at the MSB and sr[K-2] the newest stored bit. c0 = ^(v & G0), c1 = ^(v & G1). Then sr <= {in, sr[K-2:1]}.
- Puncture phase p advances once per encoded bit, including tail bits, and wraps at the period. Keep masks are {c1,c0}:
  - rate 1/2: period 1, mask 11.
  - rate 2/3: period 2, masks 11, 01.
  - rate 3/4: period 3, masks 11, 01, 10.
- Changes to rate_sel_i after frame start take effect only at the next frame start.
- bit_ct width is $clog2(FRAME_LEN+1). Tail counter width is $clog2(K).

## Timing
- Latency: a bit accepted at edge n produces its symbol, strobe and flags registered at edge n (visible in cycle n+1).
- All outputs are registered except ready_o. ready_o is combinational: !rst && state != TAIL.
- ready_o falls in the cycle after the FRAME_LEN-th accept and stays low for exactly K-1 cycles.
- The earliest next-frame accept is the cycle after frame_end_o is asserted. The frame-to-frame gap is K-1 cycles.
- Reset values: sym_o = 0, sym_valid_o = 0, sym_strobe_o = 0, frame_start_o = 0, frame_end_o = 0, frame_ct_o = 0, state = IDLE, sr = 0, p = 0.
- Reset mid-frame aborts immediately: no frame_end_o and no frame_ct_o increment. The next frame starts from the zero state.
- frame_start_o and frame_end_o never coincide, because K ≥ 3.

## Test plan
- Rate 1/2, defaults, bits 1,0,1,1 on consecutive cycles from reset:
  - sym_o = 11, 01, 00, 10, each with sym_valid_o = 11 and strobe one cycle after accept.
  - frame_start_o is high on the first symbol only.
- FRAME_LEN=8, K=3, enable held high with random data:
  - 8 data strobes, then ready_o low for 2 cycles, then 2 tail strobes.
  - frame_end_o on the 10th strobe, frame_ct_o = 1.
  - A new frame is accepted in the next cycle.
- Rate 3/4 (rate_sel_i = 2), FRAME_LEN=8, K=3:
  - sym_valid_o sequence is 11, 01, 10, repeating, across all 10 symbols.
  - Punctured bits are driven 0.
  - Switching rate_sel_i to 0 mid-frame has no effect until the next frame.
- Enable gaps: bits 1,0,1,1 with enable low for 3 cycles between each pair:
  - No strobe in the gap cycles.
  - Symbols and mask phase are identical to the gap-free run.
- Reset pulse after the 5th data bit of a frame:
  - All outputs return to 0 asynchronously, with no frame_end_o.
  - A subsequent 1,0,1,1 yields 11, 01, 00, 10 again.
- enable_encoder_i high with encoder_i = 1 throughout TAIL:
  - Tail symbols equal the zero-input encoding, i.e. sr flushes to 0.
  - frame_ct_o wraps 65535 -> 0 when preloaded via force.

Source files
------------

// File: rtl/viterbi_conv_encoder_p.sv
// viterbi_conv_encoder_p: punctured convolutional encoder (rates 1/2, 2/3, 3/4) with framed zero-tail termination
//   clk, rst            : clock, asynchronous active-high reset
//   encoder_i           : data bit, accepted when enable_encoder_i && ready_o
//   rate_sel_i          : 0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = 1/2; latched on the first bit of a frame
//   ready_o             : combinational, low in reset and while the tail is flushed
//   sym_o, sym_valid_o  : coded pair {c1,c0} and its keep mask (0 = erasure)
//   sym_strobe_o        : new symbol this cycle
//   frame_start_o/end_o : first data symbol / last tail symbol of a frame
//   frame_ct_o          : completed-frame count
module viterbi_conv_encoder_p #(
   parameter int             K         = 3,
   parameter logic [K-1:0]   G0        = 3'b111,
   parameter logic [K-1:0]   G1        = 3'b101,
   parameter int             FRAME_LEN = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        encoder_i,
   input  logic        enable_encoder_i,
   input  logic [1:0]  rate_sel_i,
   output logic        ready_o,
   output logic [1:0]  sym_o,
   output logic [1:0]  sym_valid_o,
   output logic        sym_strobe_o,
   output logic        frame_start_o,
   output logic        frame_end_o,
   output logic [15:0] frame_ct_o
);
   localparam int BW = $clog2(FRAME_LEN + 1);
   localparam int TW = $clog2(K);
   localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, TAIL = 2'd2;
   logic [1:0]    state, rate_q, p, rate, cur_p, period, p_nxt, mask, code;
   logic [K-2:0]  sr;
   logic [K-1:0]  v;
   logic [BW-1:0] bit_ct, bit_nxt;
   logic [TW-1:0] tail_ct;
   logic          accept, shift, in_bit, last_data, last_tail;
   // In IDLE the incoming bit already belongs to the new frame, so it uses the
   // live rate select and phase 0 rather than the stale registered values.
   always_comb begin
      ready_o   = !rst && state != TAIL;
      accept    = enable_encoder_i && ready_o;
      shift     = accept || state == TAIL;
      in_bit    = state != TAIL && encoder_i;
      v         = {in_bit, sr};
      code      = {^(v & G1), ^(v & G0)};
      rate      = state == IDLE ? rate_sel_i : rate_q;
      cur_p     = state == IDLE ? 2'd0 : p;
      period    = rate == 2'd1 ? 2'd2 : rate == 2'd2 ? 2'd3 : 2'd1;
      p_nxt     = cur_p + 2'd1 == period ? 2'd0 : cur_p + 2'd1;
      mask      = cur_p == 2'd0 ? 2'b11 : rate == 2'd1 ? 2'b01 : cur_p == 2'd1 ? 2'b01 : 2'b10;
      bit_nxt   = state == IDLE ? BW'(1) : bit_ct + 1'b1;
      last_data = bit_nxt == BW'(FRAME_LEN);
      last_tail = tail_ct == TW'(K - 2);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         rate_q        <= 2'd0;
         p             <= 2'd0;
         sr            <= '0;
         bit_ct        <= '0;
         tail_ct       <= '0;
         sym_o         <= 2'b00;
         sym_valid_o   <= 2'b00;
         sym_strobe_o  <= 1'b0;
         frame_start_o <= 1'b0;
         frame_end_o   <= 1'b0;
         frame_ct_o    <= 16'd0;
      end else begin
         if (shift) begin
            sr          <= {in_bit, sr[K-2:1]};
            p           <= p_nxt;
            sym_o       <= code & mask;
            sym_valid_o <= mask;
         end
         sym_strobe_o  <= shift;
         frame_start_o <= accept && state == IDLE;
         frame_end_o   <= state == TAIL && last_tail;
         if (accept) begin
            bit_ct <= bit_nxt;
            state  <= last_data ? TAIL : DATA;
            if (state == IDLE) rate_q <= rate_sel_i;
         end
         if (state == TAIL) begin
            tail_ct <= last_tail ? '0 : tail_ct + 1'b1;
            if (last_tail) begin
               state      <= IDLE;
               frame_ct_o <= frame_ct_o + 16'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_viterbi_conv_encoder_p.sv
// tb_viterbi_conv_encoder_p: randomized self-checking bench against a tap-sum reference model
module tb_viterbi_conv_encoder_p;
   localparam int K = 3, FL = 8, NS = FL + K - 1;
   localparam logic [K-1:0] G0V = 3'b111, G1V = 3'b101;
   logic        clk = 0, rst = 1, encoder_i = 0, enable_encoder_i = 0;
   logic [1:0]  rate_sel_i = 0;
   logic        ready_o, sym_strobe_o, frame_start_o, frame_end_o;
   logic [1:0]  sym_o, sym_valid_o;
   logic [15:0] frame_ct_o;
   viterbi_conv_encoder_p #(.K(K), .G0(G0V), .G1(G1V), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .encoder_i(encoder_i), .enable_encoder_i(enable_encoder_i),
      .rate_sel_i(rate_sel_i), .ready_o(ready_o), .sym_o(sym_o), .sym_valid_o(sym_valid_o),
      .sym_strobe_o(sym_strobe_o), .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
      .frame_ct_o(frame_ct_o));
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   logic [15:0] exp_fc = 0;
   typedef struct packed {logic [1:0] sym, val; logic fs, fe; logic [15:0] fc;} obs_t;
   obs_t obs[$];
   bit fb[NS];
   always @(negedge clk) if (sym_strobe_o) obs.push_back({sym_o, sym_valid_o, frame_start_o, frame_end_o, frame_ct_o});
   // Coded pair of frame position i as a tap-weighted parity over the bit history.
   function automatic logic [1:0] enc(int i);
      logic [K-1:0] g0, g1;
      logic c0, c1;
      g0 = G0V; g1 = G1V; c0 = 0; c1 = 0;
      for (int j = 0; j < K; j++)
         if (i - j >= 0) begin
            c0 ^= g0[K-1-j] & fb[i-j];
            c1 ^= g1[K-1-j] & fb[i-j];
         end
      return {c1, c0};
   endfunction
   function automatic logic [1:0] kmask(int r, int i);
      if (r == 1) return (i % 2 == 0) ? 2'b11 : 2'b01;
      if (r == 2) return (i % 3 == 0) ? 2'b11 : (i % 3 == 1) ? 2'b01 : 2'b10;
      return 2'b11;
   endfunction
   task automatic do_reset();
      enable_encoder_i = 0;
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      obs.delete();
      exp_fc = 0;
   endtask
   task automatic fill(input bit fixed);
      for (int i = 0; i < NS; i++) fb[i] = (i < FL) ? 1'($urandom) : 1'b0;
      if (fixed) begin fb[0] = 1; fb[1] = 0; fb[2] = 1; fb[3] = 1; end
   endtask
   task automatic run_frame(input int rate, input int gap, input bit tail_in, input bit sw, input bit b2b);
      int low = 0, gs = 0;
      bit done = 0;
      obs.delete();
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         if (gap > 0 && i > 0 && sym_strobe_o) gs++;
         enable_encoder_i = 1;
         encoder_i = fb[i];
         rate_sel_i = (sw && i > 0) ? 2'd0 : 2'(rate);
         if (i < FL - 1)
            for (int g = 0; g < gap; g++) begin
               @(negedge clk);
               if (g > 0 && sym_strobe_o) gs++;
               enable_encoder_i = 0;
               encoder_i = 1'($urandom);
            end
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         enable_encoder_i = tail_in;
         encoder_i = tail_in;
         if (!ready_o) low++;
         if (frame_end_o) begin
            enable_encoder_i = b2b;
            encoder_i = 1;
            rate_sel_i = 0;
            done = 1;
            break;
         end
      end
      #1;
      exp_fc = exp_fc + 16'd1;
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL frame_end_timeout: frame_end_o not seen within 20 cycles"); end
      tests++;
      if (low !== K - 1) begin fails++; $display("FAIL ready_low: %0d low cycles, expected %0d", low, K - 1); end
      tests++;
      if (obs.size() !== NS) begin fails++; $display("FAIL strobe_count: %0d strobes, expected %0d", obs.size(), NS); end
      for (int i = 0; i < NS && i < obs.size(); i++) begin
         logic [1:0] m;
         obs_t e;
         m = kmask(rate, i);
         e = {enc(i) & m, m, 1'(i == 0), 1'(i == NS - 1), obs[i].fc};
         tests++;
         if (obs[i] !== e) begin
            fails++;
            $display("FAIL sym[%0d]: sym=%b val=%b fs=%b fe=%b, expected sym=%b val=%b fs=%b fe=%b",
                     i, obs[i].sym, obs[i].val, obs[i].fs, obs[i].fe, e.sym, e.val, e.fs, e.fe);
         end
      end
      if (obs.size() == NS) begin
         tests++;
         if (obs[NS-1].fc !== exp_fc) begin fails++; $display("FAIL frame_ct: %0d, expected %0d", obs[NS-1].fc, exp_fc); end
      end
      if (gap > 0) begin
         tests++;
         if (gs !== 0) begin fails++; $display("FAIL gap_strobe: %0d strobes in gap cycles, expected 0", gs); end
      end
      if (b2b) begin
         @(negedge clk);
         tests++;
         if ({sym_strobe_o, frame_start_o, sym_o, sym_valid_o} !== 6'b11_11_11) begin
            fails++;
            $display("FAIL back_to_back: strobe=%b fs=%b sym=%b val=%b, expected 1 1 11 11",
                     sym_strobe_o, frame_start_o, sym_o, sym_valid_o);
         end
         enable_encoder_i = 0;
      end
   endtask
   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({sym_o, sym_valid_o, sym_strobe_o, frame_start_o, frame_end_o, frame_ct_o, ready_o} !== '0) begin
         fails++;
         $display("FAIL reset_state: sym=%b val=%b stb=%b fs=%b fe=%b fc=%0d rdy=%b, expected all 0",
                  sym_o, sym_valid_o, sym_strobe_o, frame_start_o, frame_end_o, frame_ct_o, ready_o);
      end
      rst = 0;
      #1;
      tests++;
      if (ready_o !== 1'b1) begin fails++; $display("FAIL ready_after_reset: %b, expected 1", ready_o); end
   endtask
   task automatic test_basic();
      logic [1:0] ex [4];
      logic [3:0] bits;
      ex = '{2'b11, 2'b01, 2'b00, 2'b10};
      bits = 4'b1101;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            tests++;
            if ({sym_strobe_o, sym_o, sym_valid_o, frame_start_o} !== {1'b1, ex[i-1], 2'b11, 1'(i == 1)}) begin
               fails++;
               $display("FAIL basic[%0d]: stb=%b sym=%b val=%b fs=%b, expected 1 %b 11 %b",
                        i - 1, sym_strobe_o, sym_o, sym_valid_o, frame_start_o, ex[i-1], i == 1);
            end
         end
         enable_encoder_i = i < 4;
         encoder_i = bits[i % 4];
         rate_sel_i = 0;
      end
      do_reset();
   endtask
   task automatic test_frame_len();
      fill(0);
      run_frame(0, 0, 0, 0, 0);
   endtask
   task automatic test_back_to_back();
      fill(0);
      run_frame(0, 0, 0, 0, 1);
      do_reset();
   endtask
   task automatic test_rate34();
      fill(0);
      run_frame(2, 0, 0, 1, 0);
   endtask
   task automatic test_gaps();
      fill(1);
      run_frame(2, 3, 0, 0, 0);
   endtask
   task automatic test_reset_midframe();
      bit fe_seen = 0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         enable_encoder_i = 1;
         encoder_i = 1'($urandom);
      end
      @(negedge clk);
      enable_encoder_i = 0;
      #2 rst = 1;
      #1;
      tests++;
      if ({sym_o, sym_valid_o, sym_strobe_o, frame_start_o, frame_end_o, frame_ct_o, ready_o} !== '0) begin
         fails++;
         $display("FAIL async_reset: sym=%b val=%b stb=%b fs=%b fe=%b fc=%0d rdy=%b, expected all 0",
                  sym_o, sym_valid_o, sym_strobe_o, frame_start_o, frame_end_o, frame_ct_o, ready_o);
      end
      foreach (obs[i]) if (obs[i].fe) fe_seen = 1;
      tests++;
      if (fe_seen !== 1'b0) begin fails++; $display("FAIL reset_no_end: frame_end_o seen=%b, expected 0", fe_seen); end
      @(negedge clk);
      rst = 0;
      exp_fc = 0;
      fill(1);
      run_frame(0, 0, 0, 0, 0);
   endtask
   task automatic test_tail_ones_wrap();
      @(negedge clk);
      force dut.frame_ct_o = 16'hFFFF;
      @(negedge clk);
      release dut.frame_ct_o;
      exp_fc = 16'hFFFF;
      fill(0);
      run_frame(1, 0, 1, 0, 0);
   endtask
   initial begin
      test_reset();
      test_basic();
      test_frame_len();
      test_back_to_back();
      test_rate34();
      test_gaps();
      test_reset_midframe();
      test_tail_ones_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
